// File: rtl/irq_encoder8.sv
// Eight-line interrupt encoder: latches requests into a pending register and presents
// one unmasked request as a 3-bit vector with a VALID/ACK handshake. Define
// IRQ_ENC_ROUND_ROBIN_EN for rotating priority instead of fixed bit-0-highest priority.
module irq_encoder8 #(
    parameter int EDGE = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] IRQ,
    input  logic [7:0] MASK,
    input  logic       EN,
    input  logic       ACK,
    output logic [2:0] CODE,
    output logic       VALID,
    output logic [7:0] PEND
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] irq_q, irq_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;

    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] cand;
    logic [2:0] win_idx;
    logic       win_found;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] rr_idx;
`endif

    // Request capture; a new set always overrides an acknowledge clear of the same bit.
    always_comb begin
        irq_d   = IRQ;
        set_vec = (EDGE != 0) ? (IRQ & ~irq_q) : IRQ;
        clr_vec = 8'h00;
        if (state_q == PRESENT && ACK) begin
            clr_vec[code_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    assign cand = pend_q & ~MASK;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    // Search upward from the pointer; 3-bit addition provides the wrap-around.
    always_comb begin
        win_idx   = 3'd0;
        win_found = 1'b0;
        rr_idx    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            rr_idx = ptr_q + 3'(k);
            if (!win_found && cand[rr_idx]) begin
                win_idx   = rr_idx;
                win_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_idx   = 3'd0;
        win_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx   = 3'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
`ifdef IRQ_ENC_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (EN && win_found) begin
                    state_d = PRESENT;
                    code_d  = win_idx;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (ACK) begin
                    state_d = HOLDOFF;
                    valid_d = 1'b0;
`ifdef IRQ_ENC_ROUND_ROBIN_EN
                    ptr_d   = code_q + 3'd1;
`endif
                end
            end
            HOLDOFF: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            irq_q   <= 8'h00;
            pend_q  <= 8'h00;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign CODE  = code_q;
    assign VALID = valid_q;
    assign PEND  = pend_q;

endmodule
